// File: rtl/vmx_seq_pkg.sv
// Shared definitions for the VMX job sequencer: FSM states, control-word
// bit positions and the wrapper state-flag decode.
package vmx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    RUN,
    ABORT
  } state_t;

  localparam int unsigned CTRL_CLR_BIT   = 0;
  localparam int unsigned CTRL_START_BIT = 1;
  localparam int unsigned FLAG_STATE_MSB = 2;

  // Wrapper reports idle as an all-zero state field.
  function automatic logic flag_active(input logic [FLAG_STATE_MSB:0] st);
    return |st;
  endfunction

endpackage

// File: rtl/vmx_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy level and a flush that wins
// over any same-cycle push or pop.
module vmx_desc_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vmx_job_sequencer.sv
// Job scheduler in front of the VMX matrix-multiply wrapper: queues
// descriptors, issues start pulses, watches for completion or a hung job.
module vmx_job_sequencer
  import vmx_seq_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          soft_clear,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  input  logic [ADDR_W-1:0]             desc_rbase,
  input  logic [ADDR_W-1:0]             desc_wbase,
  output logic [ADDR_W-1:0]             vmx_rbase,
  output logic [ADDR_W-1:0]             vmx_wbase,
  output logic [31:0]                   vmx_ctrl,
  input  logic [31:0]                   vmx_flag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              jobs_done,
  output logic                          done_pulse,
  output logic                          timeout_err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  // Compared against the pre-increment value so ABORT lands exactly
  // TIMEOUT_CYCLES cycles after the ISSUE cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  state_t              state;
  state_t              next_state;
  logic                pop;
  logic                job_done;
  logic                timeout;
  logic                wd_expire;
  logic                flag_busy;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*ADDR_W-1:0] head;
  logic [WD_W-1:0]     wdog;
  logic [31:0]         ctrl_next;
  logic                unused_flag_hi;

  vmx_desc_fifo #(
    .DATA_W (2 * ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (soft_clear),
    .push      (desc_valid),
    .push_data ({desc_rbase, desc_wbase}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign desc_ready     = !fifo_full;
  assign busy           = (state != IDLE);
  assign wd_expire      = (wdog == WD_LAST);
  assign flag_busy      = flag_active(vmx_flag[FLAG_STATE_MSB:0]);
  assign unused_flag_hi = ^vmx_flag[31:FLAG_STATE_MSB+1];

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    job_done   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE:      next_state = WAIT_START;
      WAIT_START: begin
        if (wd_expire) begin
          timeout    = 1'b1;
          next_state = ABORT;
        end else if (flag_busy) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (wd_expire) begin
          timeout    = 1'b1;
          next_state = ABORT;
        end else if (!flag_busy) begin
          job_done   = 1'b1;
          next_state = IDLE;
        end
      end
      ABORT:      next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    // soft_clear overrides everything, including a same-cycle timeout.
    if (soft_clear) begin
      pop        = 1'b0;
      job_done   = 1'b0;
      timeout    = 1'b0;
      next_state = (state == IDLE) ? IDLE : ABORT;
    end
  end

  always_comb begin
    ctrl_next = '0;
    ctrl_next[CTRL_START_BIT] = (next_state == ISSUE);
    ctrl_next[CTRL_CLR_BIT]   = (next_state == ABORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wdog        <= '0;
      vmx_rbase   <= '0;
      vmx_wbase   <= '0;
      vmx_ctrl    <= '0;
      jobs_done   <= '0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= next_state;
      vmx_ctrl   <= ctrl_next;
      done_pulse <= job_done;
      if (pop) {vmx_rbase, vmx_wbase} <= head;
      if (state == ISSUE)
        wdog <= '0;
      else if (state == WAIT_START || state == RUN)
        wdog <= wdog + WD_W'(1);
      if (soft_clear) begin
        jobs_done   <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (job_done && jobs_done != '1) jobs_done <= jobs_done + CNT_W'(1);
        if (timeout) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vmx_job_sequencer.sv
// Self-checking bench for vmx_job_sequencer with a behavioural wrapper model
// and an issue-order scoreboard.
module tb_vmx_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        soft_clear = 1'b0;
  logic        desc_valid = 1'b0;
  logic [7:0]  desc_rbase = '0;
  logic [7:0]  desc_wbase = '0;
  logic        desc_ready;
  logic [7:0]  vmx_rbase;
  logic [7:0]  vmx_wbase;
  logic [31:0] vmx_ctrl;
  logic [31:0] vmx_flag;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] jobs_done;
  logic        done_pulse;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int dones = 0;
  int exp_jobs = 0;
  logic [15:0] sb[$];

  logic [2:0] mflag;
  int         mcnt;
  bit         stuck = 1'b0;
  int         run_len = 5;

  always #5 clk = ~clk;

  vmx_job_sequencer #(
    .ADDR_W         (8),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .soft_clear  (soft_clear),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_rbase  (desc_rbase),
    .desc_wbase  (desc_wbase),
    .vmx_rbase   (vmx_rbase),
    .vmx_wbase   (vmx_wbase),
    .vmx_ctrl    (vmx_ctrl),
    .vmx_flag    (vmx_flag),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .jobs_done   (jobs_done),
    .done_pulse  (done_pulse),
    .timeout_err (timeout_err)
  );

  // Wrapper model; bit 8 is always set so only bits[2:0] may decide idle.
  assign vmx_flag = {23'h0, 1'b1, 5'h0, mflag};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mflag <= 3'd0;
      mcnt  <= 0;
    end else if (vmx_ctrl[0]) begin
      mflag <= 3'd0;
      mcnt  <= 0;
    end else if (vmx_ctrl[1]) begin
      if (stuck) begin
        mflag <= 3'd3;
        mcnt  <= 0;
      end else begin
        mflag <= 3'd4;
        mcnt  <= run_len;
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mflag <= 3'd0;
    end
  end

  always @(negedge clk) begin : monitor
    logic [15:0] exp;
    if (rst_n) begin
      checks++;
      if (vmx_ctrl !== 32'h0 && vmx_ctrl !== 32'h1 && vmx_ctrl !== 32'h2) begin
        errors++;
        $display("FAIL ctrl_legal: vmx_ctrl=%h, required 0, 1 or 2", vmx_ctrl);
      end
      if (vmx_ctrl === 32'h2) begin
        starts++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL issue_order: start with rbase=%h wbase=%h, required no start (queue empty)", vmx_rbase, vmx_wbase);
        end else begin
          exp = sb.pop_front();
          if ({vmx_rbase, vmx_wbase} !== exp) begin
            errors++;
            $display("FAIL issue_order: rbase/wbase=%h/%h, required %h/%h", vmx_rbase, vmx_wbase, exp[15:8], exp[7:0]);
          end
        end
      end
      if (done_pulse === 1'b1) dones++;
    end
  end

  task automatic push_hs(input logic [7:0] rb, input logic [7:0] wb);
    int n = 0;
    @(negedge clk);
    while (desc_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_timeout: desc_ready=%b, required 1 within 200 cycles", desc_ready);
    end else begin
      desc_valid = 1'b1;
      desc_rbase = rb;
      desc_wbase = wb;
      sb.push_back({rb, wb});
      @(posedge clk);
      #1 desc_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy === 1'b0 && fifo_level === 3'd0) && n < 1000);
    checks++;
    if (busy !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b level=%0d, required idle within 1000 cycles", name, busy, fifo_level);
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vmx_ctrl !== 32'h2 && n < 200);
    checks++;
    if (vmx_ctrl !== 32'h2) begin
      errors++;
      $display("FAIL %s_start_timeout: vmx_ctrl=%h, required 2 within 200 cycles", name, vmx_ctrl);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (vmx_ctrl !== 32'h0 || busy !== 1'b0 || fifo_level !== 3'd0 || desc_ready !== 1'b1 ||
          jobs_done !== 16'd0 || done_pulse !== 1'b0 || timeout_err !== 1'b0 ||
          vmx_rbase !== 8'h0 || vmx_wbase !== 8'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: ctrl=%h busy=%b lvl=%0d rdy=%b jobs=%0d dp=%b te=%b rb=%h wb=%h, required all 0 with rdy=1",
                 i, vmx_ctrl, busy, fifo_level, desc_ready, jobs_done, done_pulse, timeout_err, vmx_rbase, vmx_wbase);
      end
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_single;
    int bad = 0;
    int n = 0;
    enable  = 1'b1;
    run_len = 5;
    push_hs(8'h10, 8'h40);
    wait_start("single");
    @(negedge clk);
    checks++;
    if (vmx_ctrl !== 32'h0) begin
      errors++;
      $display("FAIL single_start_width: vmx_ctrl=%h one cycle after start, required 0", vmx_ctrl);
    end
    while (done_pulse !== 1'b1 && n < 100) begin
      if (vmx_rbase !== 8'h10 || vmx_wbase !== 8'h40) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_hold: %0d cycles with base changed, required 0", bad);
    end
    exp_jobs = 1;
    checks++;
    if (done_pulse !== 1'b1 || jobs_done !== 16'(exp_jobs) || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: dp=%b jobs=%0d busy=%b, required dp=1 jobs=%0d busy=0", done_pulse, jobs_done, busy, exp_jobs);
    end
    @(negedge clk);
    checks++;
    if (done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width: done_pulse=%b, required 0", done_pulse);
    end
  endtask

  task automatic test_backpressure;
    int s0;
    int d0;
    @(negedge clk);
    enable = 1'b0;
    s0 = starts;
    d0 = dones;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (desc_ready !== (i < 4) || fifo_level !== 3'(i < 4 ? i : 4)) begin
        errors++;
        $display("FAIL bp_push[%0d]: ready=%b level=%0d, required ready=%b level=%0d", i, desc_ready, fifo_level, (i < 4), (i < 4 ? i : 4));
      end
      desc_valid = 1'b1;
      desc_rbase = 8'h20 + 8'(i);
      desc_wbase = 8'h60 + 8'(i);
      if (i < 4) sb.push_back({desc_rbase, desc_wbase});
    end
    @(posedge clk);
    #1 desc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || desc_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: level=%0d ready=%b busy=%b, required 4/0/0", fifo_level, desc_ready, busy);
    end
    enable = 1'b1;
    wait_idle("bp");
    exp_jobs += 4;
    checks++;
    if (starts - s0 != 4 || dones - d0 != 4 || jobs_done !== 16'(exp_jobs) || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: starts=%0d dones=%0d jobs=%0d pending=%0d, required 4/4/%0d/0", starts - s0, dones - d0, jobs_done, sb.size(), exp_jobs);
    end
  endtask

  task automatic test_wrap;
    int s0 = starts;
    run_len = 8;
    for (int i = 0; i < 10; i++) push_hs(8'h80 + 8'(i), 8'hC0 + 8'(i));
    wait_idle("wrap");
    exp_jobs += 10;
    checks++;
    if (starts - s0 != 10 || jobs_done !== 16'(exp_jobs) || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_total: starts=%0d jobs=%0d pending=%0d, required 10/%0d/0", starts - s0, jobs_done, sb.size(), exp_jobs);
    end
  endtask

  task automatic test_timeout;
    int s0 = starts;
    int n = 0;
    @(negedge clk);
    enable  = 1'b0;
    stuck   = 1'b1;
    run_len = 4;
    push_hs(8'h21, 8'h51);
    push_hs(8'h22, 8'h52);
    enable = 1'b1;
    wait_start("timeout");
    @(posedge clk);
    #1 stuck = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (vmx_ctrl !== 32'h1 && n < 200);
    checks++;
    if (n != 64 || vmx_ctrl !== 32'h1) begin
      errors++;
      $display("FAIL timeout_latency: abort after %0d cycles ctrl=%h, required 64 cycles ctrl=1", n, vmx_ctrl);
    end
    checks++;
    if (timeout_err !== 1'b1 || jobs_done !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL timeout_flag: te=%b jobs=%0d, required te=1 jobs=%0d", timeout_err, jobs_done, exp_jobs);
    end
    @(negedge clk);
    checks++;
    if (vmx_ctrl !== 32'h0) begin
      errors++;
      $display("FAIL timeout_clr_width: vmx_ctrl=%h, required 0", vmx_ctrl);
    end
    wait_idle("timeout");
    exp_jobs += 1;
    checks++;
    if (starts - s0 != 2 || jobs_done !== 16'(exp_jobs) || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: starts=%0d jobs=%0d te=%b, required 2/%0d/1", starts - s0, jobs_done, timeout_err, exp_jobs);
    end
  endtask

  task automatic test_soft_clear;
    run_len = 30;
    push_hs(8'h41, 8'h71);
    wait_start("sclr");
    push_hs(8'h42, 8'h72);
    push_hs(8'h43, 8'h73);
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd2 || busy !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL sclr_pre: level=%0d busy=%b te=%b, required 2/1/1", fifo_level, busy, timeout_err);
    end
    soft_clear = 1'b1;
    desc_valid = 1'b1;
    desc_rbase = 8'hEE;
    desc_wbase = 8'hEF;
    sb.delete();
    @(negedge clk);
    soft_clear = 1'b0;
    desc_valid = 1'b0;
    exp_jobs   = 0;
    checks++;
    if (vmx_ctrl !== 32'h1 || fifo_level !== 3'd0 || jobs_done !== 16'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL sclr_abort: ctrl=%h level=%0d jobs=%0d te=%b, required 1/0/0/0", vmx_ctrl, fifo_level, jobs_done, timeout_err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vmx_ctrl !== 32'h0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL sclr_after: busy=%b ctrl=%h level=%0d, required 0/0/0", busy, vmx_ctrl, fifo_level);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || jobs_done !== 16'd0) begin
      errors++;
      $display("FAIL sclr_quiet: busy=%b jobs=%0d, required 0/0", busy, jobs_done);
    end
  endtask

  task automatic test_reset_midrun;
    int s0;
    run_len = 30;
    push_hs(8'h31, 8'h91);
    wait_start("rst");
    push_hs(8'h32, 8'h92);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vmx_ctrl !== 32'h0 || busy !== 1'b0 || fifo_level !== 3'd0 || desc_ready !== 1'b1 || vmx_rbase !== 8'h0) begin
      errors++;
      $display("FAIL rst_async: ctrl=%h busy=%b level=%0d ready=%b rb=%h, required 0/0/0/1/0", vmx_ctrl, busy, fifo_level, desc_ready, vmx_rbase);
    end
    sb.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    exp_jobs = 0;
    s0       = starts;
    run_len  = 4;
    push_hs(8'h33, 8'h93);
    wait_idle("rst");
    exp_jobs = 1;
    checks++;
    if (starts - s0 != 1 || jobs_done !== 16'(exp_jobs) || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: starts=%0d jobs=%0d te=%b, required 1/%0d/0", starts - s0, jobs_done, timeout_err, exp_jobs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_soft_clear();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at 2 ms, required completion");
    $fatal(1);
  end

endmodule
